// File: rtl/mem_bus_arbiter.sv
// mem_bus_arbiter: shares the external memory bus between the instruction
// cache (F side) and the data writeback cache controller (M side). A grant
// is held for the whole multi-beat transaction while the owner keeps its
// request high.
// Optional feature: define MEM_BUS_ARB_ROUND_ROBIN_EN to give ties to the
// master that did not own the bus last; otherwise M wins every tie.
module mem_bus_arbiter #(
   parameter int BURSTLEN = 4
) (
   input  logic                                     clk,
   input  logic                                     reset,
   input  logic                                     HRequestF,
   input  logic                                     HWriteF,
   input  logic [31:0]                              HAddrF,
   input  logic                                     HRequestM,
   input  logic                                     HWriteM,
   input  logic [31:0]                              HAddrM,
   input  logic [31:0]                              HWDataM,
   input  logic [3:0]                               ByteMaskM,
   input  logic                                     BusReady,
   output logic                                     HRequest,
   output logic                                     HWrite,
   output logic [31:0]                              HAddr,
   output logic [31:0]                              HWData,
   output logic [3:0]                               HByteMask,
   output logic                                     BusReadyF,
   output logic                                     BusReadyM,
   output logic                                     GrantF,
   output logic                                     GrantM,
   output logic [((BURSTLEN > 1) ? $clog2(BURSTLEN) : 1)-1:0] BeatCount
);

   localparam int BW = (BURSTLEN > 1) ? $clog2(BURSTLEN) : 1;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      OWN_F = 2'd1,
      OWN_M = 2'd2
   } state_t;

   state_t          state_q, state_d;
   logic            GrantF_q, GrantM_q;
   logic [BW-1:0]   BeatCount_q, BeatCount_d;
   logic            pick_f;   // winner of a simultaneous request in IDLE

`ifdef MEM_BUS_ARB_ROUND_ROBIN_EN
   logic            LastOwnerM_q;   // 1: M was the most recent owner
   assign pick_f = LastOwnerM_q;
`else
   assign pick_f = 1'b0;
`endif

   // Next owner: grants are only released when the owner drops its request.
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE: begin
            if (HRequestF && HRequestM) state_d = pick_f ? OWN_F : OWN_M;
            else if (HRequestM)         state_d = OWN_M;
            else if (HRequestF)         state_d = OWN_F;
            else                        state_d = IDLE;
         end
         OWN_F:   if (!HRequestF) state_d = HRequestM ? OWN_M : IDLE;
         OWN_M:   if (!HRequestM) state_d = HRequestF ? OWN_F : IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Beat counter: restarts on every new grant, counts forwarded ready pulses.
   always_comb begin
      BeatCount_d = BeatCount_q;
      if (state_d != state_q || state_d == IDLE)
         BeatCount_d = '0;
      else if (BusReady)
         BeatCount_d = (BeatCount_q == BW'(BURSTLEN - 1)) ? '0 : BeatCount_q + 1'b1;
   end

   // Arbiter state, registered grants and beat count.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q      <= IDLE;
         GrantF_q     <= 1'b0;
         GrantM_q     <= 1'b0;
         BeatCount_q  <= '0;
`ifdef MEM_BUS_ARB_ROUND_ROBIN_EN
         LastOwnerM_q <= 1'b0;
`endif
      end else begin
         state_q     <= state_d;
         GrantF_q    <= (state_d == OWN_F);
         GrantM_q    <= (state_d == OWN_M);
         BeatCount_q <= BeatCount_d;
`ifdef MEM_BUS_ARB_ROUND_ROBIN_EN
         if (state_d == OWN_M && state_q != OWN_M)      LastOwnerM_q <= 1'b1;
         else if (state_d == OWN_F && state_q != OWN_F) LastOwnerM_q <= 1'b0;
`endif
      end
   end

   // Bus mux: zero-latency copy of the owner's signals, all zero when idle.
   always_comb begin
      HRequest  = 1'b0;
      HWrite    = 1'b0;
      HAddr     = '0;
      HWData    = '0;
      HByteMask = '0;
      if (GrantF_q) begin
         HRequest  = HRequestF;
         HWrite    = HWriteF;
         HAddr     = HAddrF;
         HByteMask = 4'b1111;   // instruction fetches are full-word reads
      end else if (GrantM_q) begin
         HRequest  = HRequestM;
         HWrite    = HWriteM;
         HAddr     = HAddrM;
         HWData    = HWDataM;
         HByteMask = ByteMaskM;
      end
   end

   assign BusReadyF = BusReady & GrantF_q;
   assign BusReadyM = BusReady & GrantM_q;
   assign GrantF    = GrantF_q;
   assign GrantM    = GrantM_q;
   assign BeatCount = BeatCount_q;

endmodule

// File: doc/mem_bus_arbiter.md
# mem_bus_arbiter

Two-master arbiter sharing the single external memory bus between the instruction cache (F side) and the data writeback cache controller (M side). It grants exactly one master at a time and holds the grant for the whole multi-beat transaction: writeback, refill and byte-write sequences stay atomic while the master holds its request. It routes that master's request, address, write data and byte mask onto the bus, and returns `BusReady` only to the owner.

## Interface
- `BURSTLEN`, 4: words per cache block; sets `BeatCount` width (`$clog2(BURSTLEN)`).
- `clk` in 1: clock; all state changes on the rising edge.
- `reset` in 1: **one clock; reset is asynchronous and active-low**.
- `HRequestF` in 1: instruction-side request, held for its whole transaction.
- `HWriteF` in 1: instruction-side write; normally 0.
- `HAddrF` in 32: instruction-side address.
- `HRequestM` in 1: data-side request (cache `Stall`), held for its whole transaction.
- `HWriteM` in 1: data-side write.
- `HAddrM` in 32: data-side address.
- `HWDataM` in 32: data-side write data.
- `ByteMaskM` in 4: data-side byte enables.
- `BusReady` in 1: memory completed one beat this cycle.
- `HRequest` out 1: bus request.
- `HWrite` out 1: bus write.
- `HAddr` out 32: bus address.
- `HWData` out 32: bus write data. It is 0 when the F side owns the bus.
- `HByteMask` out 4: bus byte enables. It is 4'b1111 when the F side owns the bus.
- `BusReadyF` out 1: `BusReady` gated to the F owner.
- `BusReadyM` out 1: `BusReady` gated to the M owner.
- `GrantF` out 1: F owns the bus (registered).
- `GrantM` out 1: M owns the bus (registered).
- `BeatCount` out `$clog2(BURSTLEN)`: beats completed in the current grant.

## Operation
- State machine with three states: IDLE, OWN_F, OWN_M. There is a one-bit `LastOwner` register.
- **IDLE**
  - M only requesting → OWN_M.
  - F only requesting → OWN_F.
  - Both requesting → choose by the priority policy (see Configuration).
  - Neither requesting → stay in IDLE.
- **OWN_x**
  - Stay while `HRequestx`=1.
  - When `HRequestx`=0:
    - The other master is requesting → go directly to OWN_other (no idle cycle).
    - Otherwise → go to IDLE.
- `LastOwner` updates on every entry into an OWN state.
- **Bus outputs**
  - In OWN_x the bus outputs are combinational copies of master x's signals, with `HRequest`=`HRequestx`.
  - In IDLE all bus outputs are 0.
- **BusReady routing**
  - `BusReadyx` = `BusReady` & `Grantx`.
  - `BusReady` while IDLE is dropped.
  - `BusReady` in the cycle the owner drops its request is still forwarded to the owner.
- **BeatCount**
  - Clears on entry into any OWN state and in IDLE.
  - Increments on each forwarded `BusReady` and wraps modulo `BURSTLEN` (3 → 0 at `BURSTLEN`=4).
- **Reset** (asserted at any time, including mid-burst): state=IDLE, `GrantF`=`GrantM`=0, `BeatCount`=0, `LastOwner`=F. All outputs therefore read 0.

## Timing
- Arbitration latency: a request seen in IDLE at edge N gives `Grantx`=1 and bus outputs valid in cycle N+1. A master waits at least one cycle from its request.
- Handoff: owner drops its request in cycle N → new owner drives the bus in cycle N+1. `HRequest`=0 during cycle N.
- The grant never changes while the owner's request is high, regardless of the other master's request.
- The bus outputs carry the owner's inputs with zero added latency; the arbiter adds no pipeline stage on address or data.
- Simultaneous new requests in IDLE are resolved in one cycle and never produce a double grant. `GrantF` & `GrantM` = 0 always.

## Configuration
- `MEM_BUS_ARB_ROUND_ROBIN_EN`
  - Defined: a tie in IDLE, or a handoff decision, goes to the master that is not `LastOwner`.
  - Undefined: fixed priority, M wins every tie (the older pipeline stage), and `LastOwner` is unused.
- Both builds use the same ports.

## Test plan
- Reset: assert `reset`=0 mid-OWN_M burst with `BeatCount`=2 → next cycle all outputs 0 and state IDLE. Releasing reset with `HRequestF`=1 → `GrantF`=1 one cycle later.
- Single M refill: `HRequestM`=1 for 4 `BusReady` pulses at addresses 0x100..0x10C → `GrantM`=1, `BeatCount` 0→1→2→3→0, `BusReadyF` always 0.
- Non-preemption: M owns the bus, F raises its request mid-burst → `GrantM` stays 1 until `HRequestM`=0. `GrantF`=1 the following cycle, with no IDLE cycle between.
- Tie: both request in IDLE after reset → M wins (`LastOwner`=F initially). A repeated tie after M releases goes to F with round-robin enabled, and to M without it.
- Byte masking: F owner with `ByteMaskM`=4'b0011 and `HWDataM`=0xDEADBEEF → `HByteMask`=4'b1111, `HWData`=0. Switching to M gives 4'b0011 and 0xDEADBEEF.
- Stray ready: `BusReady`=1 in IDLE → `BusReadyF`=`BusReadyM`=0 and `BeatCount` stays 0.
